// File: rtl/image_loader.sv
// -----------------------------------------------------------------------------
// image_loader
//
// Front-end stage of the MNIST BNN, active while the top-level FSM is in LOAD.
// Unpacks a 107-byte stream (LSB first) into the 28x28 binary image and the
// eight 3x3 binary kernels. Bytes 0-97 fill the image row-major, bytes 98-106
// fill the kernels (kernel, row, column order). load_done tells the top-level
// FSM it may advance to LAYER_1.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset (clears arrays, counter, flag)
//   state       top-level FSM state (IDLE restarts the frame, LOAD accepts)
//   data_in     stream byte
//   data_valid  data_in is valid this cycle
//   ready       loader accepts a byte this cycle (combinational)
//   pixels      pixels[r][c], registered image
//   weights     weights[k][r][c], registered kernels
//   load_done   full frame received (registered)
// -----------------------------------------------------------------------------
module image_loader (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           state,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    output logic                 ready,
    output logic [27:0][27:0]    pixels,
    output logic [7:0][2:0][2:0] weights,
    output logic                 load_done
);

    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_LOAD = 3'b001;

    localparam logic [6:0] FIRST_WEIGHT_BYTE = 7'd98;
    localparam logic [6:0] LAST_BYTE         = 7'd106;

    logic [6:0] byte_cnt;
    logic [4:0] row_ptr;
    logic [4:0] col_ptr;
    logic [2:0] ker_ptr;
    logic [1:0] kr_ptr;
    logic [1:0] kc_ptr;

    logic       accept;
    logic       image_phase;

    // Per-bit write targets for the current byte, plus the pointers after it
    logic [4:0] bit_row [8];
    logic [4:0] bit_col [8];
    logic [2:0] bit_ker [8];
    logic [1:0] bit_kr  [8];
    logic [1:0] bit_kc  [8];
    logic [4:0] row_nxt;
    logic [4:0] col_nxt;
    logic [2:0] ker_nxt;
    logic [1:0] kr_nxt;
    logic [1:0] kc_nxt;

    assign ready       = (state == ST_LOAD) && !load_done;
    assign accept      = data_valid && ready;
    assign image_phase = (byte_cnt < FIRST_WEIGHT_BYTE);

    // Walk the eight bit positions of the current byte one step at a time.
    // A byte spans at most one row (28) or kernel (9) boundary, so single-step
    // wrap compares replace any division by 28 or 9. The image row pointer
    // may reach 28 after the last image byte; it is never used as a write
    // target because the counter has moved into the weight phase by then.
    always_comb begin
        logic [4:0] r;
        logic [4:0] c;
        logic [2:0] k;
        logic [1:0] kr;
        logic [1:0] kc;
        r = row_ptr;
        c = col_ptr;
        k = ker_ptr;
        kr = kr_ptr;
        kc = kc_ptr;
        for (int i = 0; i < 8; i++) begin
            bit_row[i] = r;
            bit_col[i] = c;
            bit_ker[i] = k;
            bit_kr[i]  = kr;
            bit_kc[i]  = kc;
            if (c == 5'd27) begin
                c = 5'd0;
                r = r + 5'd1;
            end else begin
                c = c + 5'd1;
            end
            if (kc == 2'd2) begin
                kc = 2'd0;
                if (kr == 2'd2) begin
                    kr = 2'd0;
                    k  = k + 3'd1;
                end else begin
                    kr = kr + 2'd1;
                end
            end else begin
                kc = kc + 2'd1;
            end
        end
        row_nxt = r;
        col_nxt = c;
        ker_nxt = k;
        kr_nxt  = kr;
        kc_nxt  = kc;
    end

    // Reset beats IDLE restart, which beats accept. IDLE restart leaves the
    // arrays alone so a partially reloaded frame keeps the old contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixels    <= '0;
            weights   <= '0;
            byte_cnt  <= '0;
            row_ptr   <= '0;
            col_ptr   <= '0;
            ker_ptr   <= '0;
            kr_ptr    <= '0;
            kc_ptr    <= '0;
            load_done <= 1'b0;
        end else if (state == ST_IDLE) begin
            byte_cnt  <= '0;
            row_ptr   <= '0;
            col_ptr   <= '0;
            ker_ptr   <= '0;
            kr_ptr    <= '0;
            kc_ptr    <= '0;
            load_done <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < 8; i++) begin
                if (image_phase) begin
                    pixels[bit_row[i]][bit_col[i]] <= data_in[i];
                end else begin
                    weights[bit_ker[i]][bit_kr[i]][bit_kc[i]] <= data_in[i];
                end
            end
            if (image_phase) begin
                row_ptr <= row_nxt;
                col_ptr <= col_nxt;
            end else begin
                ker_ptr <= ker_nxt;
                kr_ptr  <= kr_nxt;
                kc_ptr  <= kc_nxt;
            end
            byte_cnt <= byte_cnt + 7'd1;
            if (byte_cnt == LAST_BYTE) begin
                load_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// -----------------------------------------------------------------------------
// tb_image_loader
//
// Directed self-checking bench for image_loader. Drives bytes shortly after
// each rising edge and samples outputs 1 ns after the edge that captured them.
// -----------------------------------------------------------------------------
module tb_image_loader;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_LOAD    = 3'b001;
    localparam logic [2:0] ST_LAYER_1 = 3'b010;

    logic                 clk;
    logic                 rst_n;
    logic [2:0]           state;
    logic [7:0]           data_in;
    logic                 data_valid;
    logic                 ready;
    logic [27:0][27:0]    pixels;
    logic [7:0][2:0][2:0] weights;
    logic                 load_done;

    int check_count;
    int error_count;

    image_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .pixels     (pixels),
        .weights    (weights),
        .load_done  (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One byte with data_valid for a single edge
    task automatic applyStimulus(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    // 107 bytes with data_valid held high. kind 0: all 0x55.
    // kind 1: 99 x 0xFF, 0x01, then 7 x 0x00.
    task automatic applyFrame(input int kind);
        logic [7:0] b;
        for (int i = 0; i < 107; i++) begin
            if (kind == 0)      b = 8'h55;
            else if (i < 99)    b = 8'hFF;
            else if (i == 99)   b = 8'h01;
            else                b = 8'h00;
            data_in    = b;
            data_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i == 105) begin
                checkOutput("done_before_last", 64'(load_done), 64'd0);
                checkOutput("ready_before_last", 64'(ready), 64'd1);
            end
        end
        checkOutput("done_after_last", 64'(load_done), 64'd1);
        checkOutput("ready_after_last", 64'(ready), 64'd0);
        data_valid = 1'b0;
    endtask

    task automatic idleRestart();
        state = ST_IDLE;
        @(posedge clk);
        #1;
        state = ST_LOAD;
        #1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst_n       = 1'b0;
        state       = ST_IDLE;
        data_in     = 8'h00;
        data_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_pixels", 64'($countones(pixels)), 64'd0);
        checkOutput("rst_weights", 64'($countones(weights)), 64'd0);
        checkOutput("rst_done", 64'(load_done), 64'd0);
        checkOutput("rst_ready_idle", 64'(ready), 64'd0);

        $display("[TB] first byte");
        state = ST_LOAD;
        #1;
        checkOutput("ready_load", 64'(ready), 64'd1);
        applyStimulus(8'h01);
        checkOutput("first_row0", 64'(pixels[0]), 64'h0000001);
        checkOutput("first_count", 64'($countones(pixels)), 64'd1);
        checkOutput("first_done", 64'(load_done), 64'd0);
        checkOutput("first_ready", 64'(ready), 64'd1);

        $display("[TB] row wrap");
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'hF0);
        checkOutput("wrap_row0_hi", 64'(pixels[0][27:24]), 64'h0);
        checkOutput("wrap_row1_lo", 64'(pixels[1][3:0]), 64'hF);
        checkOutput("wrap_row1", 64'(pixels[1]), 64'h000000F);

        $display("[TB] byte outside LOAD");
        state = ST_LAYER_1;
        #1;
        checkOutput("layer1_ready", 64'(ready), 64'd0);
        applyStimulus(8'hAA);
        checkOutput("layer1_count", 64'($countones(pixels)), 64'd5);
        checkOutput("layer1_row1", 64'(pixels[1]), 64'h000000F);
        state = ST_LOAD;
        #1;
        applyStimulus(8'hFF);
        checkOutput("resume_row1", 64'(pixels[1]), 64'h0000FFF);

        $display("[TB] mid-frame reset");
        for (int i = 0; i < 45; i++) applyStimulus(8'hFF);
        checkOutput("fifty_count", 64'($countones(pixels)), 64'd373);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_pixels", 64'($countones(pixels)), 64'd0);
        checkOutput("midrst_weights", 64'($countones(weights)), 64'd0);
        checkOutput("midrst_done", 64'(load_done), 64'd0);
        checkOutput("midrst_ready", 64'(ready), 64'd1);

        $display("[TB] 0x55 frame");
        applyFrame(0);
        for (int r = 0; r < 28; r++) begin
            checkOutput($sformatf("p55_row%0d", r), 64'(pixels[r]), 64'h5555555);
        end
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("p55_ker%0d", k), 64'(weights[k]),
                        (k % 2 == 0) ? 64'h155 : 64'h0AA);
        end

        $display("[TB] byte after done");
        applyStimulus(8'hAA);
        checkOutput("after_done_row0", 64'(pixels[0]), 64'h5555555);
        checkOutput("after_done_ker0", 64'(weights[0]), 64'h155);
        checkOutput("after_done_flag", 64'(load_done), 64'd1);

        $display("[TB] IDLE restart");
        idleRestart();
        checkOutput("restart_done", 64'(load_done), 64'd0);
        checkOutput("restart_ready", 64'(ready), 64'd1);
        applyStimulus(8'h00);
        checkOutput("restart_row0", 64'(pixels[0]), 64'h5555500);
        checkOutput("restart_row1", 64'(pixels[1]), 64'h5555555);
        checkOutput("restart_ker1", 64'(weights[1]), 64'h0AA);

        $display("[TB] full frame");
        idleRestart();
        applyFrame(1);
        checkOutput("full_pixels", 64'($countones(pixels)), 64'd784);
        checkOutput("full_row27", 64'(pixels[27]), 64'hFFFFFFF);
        checkOutput("full_ker0", 64'(weights[0]), 64'h1FF);
        checkOutput("full_weights", 64'($countones(weights)), 64'd9);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
